// File: rtl/vec_cache_rdb_agent_mb.sv
`default_nettype none
// ============================================================================
// Module   : vec_cache_rdb_agent_mb
// Purpose  : Multi-bank read-data-buffer agent sitting between the dataram
//            read arbiter and the upstream return path. A buffer entry is
//            reserved when a request is accepted. SRAM data is captured
//            RD_LAT cycles later, and beats return upstream in accept order
//            through a 2-entry skid with vld/rdy backpressure.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst_n                        clock, asynchronous active-low reset
//   req_vld/req_rdy                   request handshake (req_rdy = free_cnt!=0)
//   req_rob_id/req_txnid/req_sb       request payload
//   ram_data_vld/ram_data             SRAM return, exactly RD_LAT after accept
//   out_vld/out_rdy                   upstream beat handshake
//   out_data/out_rob_id/out_txnid/out_sb  upstream beat payload
//   done/done_idx                     1-cycle rob release pulse and its rob id
//   nfull                             free_cnt >= NFULL_THRESH
//   free_cnt                          number of unreserved entries
//   lat_err                           sticky latency-slot error
//   stall_cnt                         (RDB_STALL_CNT_EN only) saturating count
//                                     of cycles with out_vld & !out_rdy
// Configuration macro: RDB_STALL_CNT_EN
// ============================================================================
module vec_cache_rdb_agent_mb #(
  parameter int NUM_BANK     = 2,
  parameter int BANK_DEPTH   = 8,
  parameter int DATA_W       = 1024,
  parameter int ROB_ID_W     = 6,
  parameter int TXN_W        = 12,
  parameter int SB_W         = 16,
  parameter int RD_LAT       = 10,
  parameter int NFULL_THRESH = 4
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic                                        req_vld,
  output logic                                        req_rdy,
  input  logic [ROB_ID_W-1:0]                         req_rob_id,
  input  logic [TXN_W-1:0]                            req_txnid,
  input  logic [SB_W-1:0]                             req_sb,
  input  logic                                        ram_data_vld,
  input  logic [DATA_W-1:0]                           ram_data,
  output logic                                        out_vld,
  input  logic                                        out_rdy,
  output logic [DATA_W-1:0]                           out_data,
  output logic [ROB_ID_W-1:0]                         out_rob_id,
  output logic [TXN_W-1:0]                            out_txnid,
  output logic [SB_W-1:0]                             out_sb,
  output logic                                        done,
  output logic [ROB_ID_W-1:0]                         done_idx,
  output logic                                        nfull,
  output logic [$clog2(NUM_BANK*BANK_DEPTH):0]        free_cnt,
`ifdef RDB_STALL_CNT_EN
  output logic [31:0]                                 stall_cnt,
`endif
  output logic                                        lat_err
);

  localparam int N      = NUM_BANK * BANK_DEPTH;
  localparam int SLOT_W = $clog2(N);
  localparam int BANK_W = $clog2(NUM_BANK);
  localparam int ENT_W  = $clog2(BANK_DEPTH);
  localparam int CNT_W  = SLOT_W + 1;

  // A slot index is {bank, entry}; bank occupies the upper bits.
  logic [N-1:0]          r_busy;
  logic [N-1:0]          r_filled;
  logic [BANK_W-1:0]     r_bank_ptr;
  logic [CNT_W-1:0]      r_free_cnt;
  logic                  r_done;
  logic [ROB_ID_W-1:0]   r_done_idx;
  logic                  r_lat_err;

  // Per-slot storage (no reset needed: guarded by r_busy / r_filled)
  logic [DATA_W-1:0]     r_ram  [N];
  logic [ROB_ID_W-1:0]   r_rob  [N];
  logic [TXN_W-1:0]      r_txn  [N];
  logic [SB_W-1:0]       r_sb   [N];

  // Latency delay line
  logic [RD_LAT-1:0]     r_dl_vld;
  logic [SLOT_W-1:0]     r_dl_slot [RD_LAT];

  // Accept-order FIFO of slot indices
  logic [SLOT_W-1:0]     r_ord [N];
  logic [SLOT_W-1:0]     r_ord_wp;
  logic [SLOT_W-1:0]     r_ord_rp;
  logic [CNT_W-1:0]      r_ord_cnt;

  // Output skid
  logic [1:0]            r_sk_cnt;
  logic                  r_sk_wp;
  logic                  r_sk_rp;
  logic [DATA_W-1:0]     r_sk_data [2];
  logic [ROB_ID_W-1:0]   r_sk_rob  [2];
  logic [TXN_W-1:0]      r_sk_txn  [2];
  logic [SB_W-1:0]       r_sk_sb   [2];
  logic [SLOT_W-1:0]     r_sk_slot [2];

  logic                  w_alloc_ok;
  logic [SLOT_W-1:0]     w_alloc_slot;
  logic [BANK_W-1:0]     w_alloc_bk;
  logic                  w_acc;
  logic                  w_hd_vld;
  logic [SLOT_W-1:0]     w_hd_slot;
  logic                  w_wr_en;
  logic [SLOT_W-1:0]     w_ord_slot;
  logic                  w_bank_conflict;
  logic                  w_sk_room;
  logic                  w_rd_issue;
  logic                  w_out_fire;
  logic [N-1:0]          w_busy_set;
  logic [N-1:0]          w_fill_set;
  logic [N-1:0]          w_free_clr;

  // Allocation: start at the round-robin bank, fall through to the next bank
  // in RR order that still has a free entry; lowest free entry wins.
  always_comb begin
    w_alloc_ok   = 1'b0;
    w_alloc_slot = '0;
    w_alloc_bk   = '0;
    for (int k = 0; k < NUM_BANK; k++) begin
      if (!w_alloc_ok) begin
        w_alloc_bk = BANK_W'(int'(r_bank_ptr) + k);
        for (int e = BANK_DEPTH - 1; e >= 0; e--) begin
          if (!r_busy[{w_alloc_bk, ENT_W'(e)}]) begin
            w_alloc_ok   = 1'b1;
            w_alloc_slot = {w_alloc_bk, ENT_W'(e)};
          end
        end
      end
    end
  end

  assign req_rdy    = (r_free_cnt != '0);
  assign w_acc      = req_vld & req_rdy & w_alloc_ok;

  assign w_hd_vld   = r_dl_vld[RD_LAT-1];
  assign w_hd_slot  = r_dl_slot[RD_LAT-1];
  assign w_wr_en    = w_hd_vld & ram_data_vld;

  // The SRAM write owns its bank this cycle; a read to another bank may
  // still proceed. A read lands in the skid at the same edge a pop frees room.
  assign w_ord_slot      = r_ord[r_ord_rp];
  assign w_bank_conflict = w_wr_en &
                           (w_hd_slot[SLOT_W-1:ENT_W] == w_ord_slot[SLOT_W-1:ENT_W]);
  assign out_vld    = (r_sk_cnt != 2'd0);
  assign w_out_fire = out_vld & out_rdy;
  assign w_sk_room  = (r_sk_cnt != 2'd2) | w_out_fire;
  assign w_rd_issue = (r_ord_cnt != '0) & r_filled[w_ord_slot] &
                      ~w_bank_conflict & w_sk_room;

  // A missing beat still marks the slot filled so the order FIFO never stalls.
  assign w_busy_set = w_acc      ? (N'(1) << w_alloc_slot)        : '0;
  assign w_fill_set = w_hd_vld   ? (N'(1) << w_hd_slot)           : '0;
  assign w_free_clr = w_out_fire ? (N'(1) << r_sk_slot[r_sk_rp])  : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy     <= '0;
      r_filled   <= '0;
      r_bank_ptr <= '0;
      r_free_cnt <= CNT_W'(N);
      r_done     <= 1'b0;
      r_done_idx <= '0;
      r_lat_err  <= 1'b0;
      r_dl_vld   <= '0;
      r_ord_wp   <= '0;
      r_ord_rp   <= '0;
      r_ord_cnt  <= '0;
      r_sk_cnt   <= 2'd0;
      r_sk_wp    <= 1'b0;
      r_sk_rp    <= 1'b0;
    end else begin
      r_busy   <= (r_busy   | w_busy_set) & ~w_free_clr;
      r_filled <= (r_filled | w_fill_set) & ~w_free_clr;
      r_dl_vld <= {r_dl_vld[RD_LAT-2:0], w_acc};

      if (w_acc) begin
        r_bank_ptr <= r_bank_ptr + BANK_W'(1);
        r_ord_wp   <= r_ord_wp + SLOT_W'(1);
      end
      if (w_rd_issue) begin
        r_ord_rp <= r_ord_rp + SLOT_W'(1);
        r_sk_wp  <= ~r_sk_wp;
      end
      if (w_out_fire) begin
        r_sk_rp <= ~r_sk_rp;
      end

      r_ord_cnt  <= r_ord_cnt + CNT_W'(w_acc) - CNT_W'(w_rd_issue);
      r_sk_cnt   <= r_sk_cnt + 2'(w_rd_issue) - 2'(w_out_fire);
      r_free_cnt <= r_free_cnt - CNT_W'(w_acc) + CNT_W'(w_out_fire);

      r_done     <= w_out_fire;
      r_done_idx <= w_out_fire ? r_sk_rob[r_sk_rp] : '0;

      if (w_hd_vld ^ ram_data_vld) begin
        r_lat_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    r_dl_slot[0] <= w_alloc_slot;
    for (int i = 1; i < RD_LAT; i++) begin
      r_dl_slot[i] <= r_dl_slot[i-1];
    end
    if (w_acc) begin
      r_ord[r_ord_wp]     <= w_alloc_slot;
      r_rob[w_alloc_slot] <= req_rob_id;
      r_txn[w_alloc_slot] <= req_txnid;
      r_sb[w_alloc_slot]  <= req_sb;
    end
    if (w_wr_en) begin
      r_ram[w_hd_slot] <= ram_data;
    end
    if (w_rd_issue) begin
      r_sk_data[r_sk_wp] <= r_ram[w_ord_slot];
      r_sk_rob[r_sk_wp]  <= r_rob[w_ord_slot];
      r_sk_txn[r_sk_wp]  <= r_txn[w_ord_slot];
      r_sk_sb[r_sk_wp]   <= r_sb[w_ord_slot];
      r_sk_slot[r_sk_wp] <= w_ord_slot;
    end
  end

  assign out_data   = r_sk_data[r_sk_rp];
  assign out_rob_id = r_sk_rob[r_sk_rp];
  assign out_txnid  = r_sk_txn[r_sk_rp];
  assign out_sb     = r_sk_sb[r_sk_rp];
  assign done       = r_done;
  assign done_idx   = r_done_idx;
  assign free_cnt   = r_free_cnt;
  assign nfull      = (r_free_cnt >= CNT_W'(NFULL_THRESH));
  assign lat_err    = r_lat_err;

`ifdef RDB_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= 32'd0;
    end else if (out_vld & ~out_rdy & ~(&r_stall_cnt)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`else
  // Stall counter not built.
`endif

endmodule
`default_nettype wire
